demux_stream_registered: RTL and testbench

//  Registered 1-to-NUM_OUT stream demultiplexer; the inverse of the 2:1 mux used in the datapath.

---
 rtl/demux_stream_registered.sv | 96 +++++++++
 tb/tb_demux_stream_registered.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_registered.sv
// rtl/demux_stream_registered.sv - registered 1-to-NUM_OUT valid/ready stream demultiplexer
// Each channel owns a one-entry holding register; destination from in_sel or a round-robin pointer.
module demux_stream_registered #(
  parameter int DATA_W      = 8,
  parameter int NUM_OUT     = 4,
  parameter int ROUND_ROBIN = 0,
  parameter int SEL_W       = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic                      sel_err,
  output logic [SEL_W-1:0]          rr_ptr
);

  localparam logic [SEL_W:0]   NUM_OUT_W = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] RR_LAST   = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0]   dst;
  logic               dst_ok;
  logic               dst_ready;
  logic               accept;
  logic               wr_en;

  logic [NUM_OUT-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]  data_q [NUM_OUT];
  logic [DATA_W-1:0]  data_d [NUM_OUT];
  logic               sel_err_q, sel_err_d;
  logic [SEL_W-1:0]   rr_q, rr_d;

  assign dst    = (ROUND_ROBIN != 0) ? rr_q : in_sel;
  assign dst_ok = ({1'b0, dst} < NUM_OUT_W);

  // Readiness looks only at the addressed channel, so one stalled consumer never blocks another.
  always_comb begin
    dst_ready = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (dst == SEL_W'(k)) begin
        dst_ready = ~valid_q[k] | out_ready[k];
      end
    end
  end

  assign in_ready = rst_n & (~dst_ok | dst_ready);
  assign accept   = in_valid & in_ready;
  assign wr_en    = accept & dst_ok;

  // A write into a draining channel overrides the drain, giving full per-channel throughput.
  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (wr_en && (dst == SEL_W'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
  end

  always_comb begin
    sel_err_d = accept & ~dst_ok;
    rr_d      = rr_q;
    if ((ROUND_ROBIN != 0) && accept) begin
      rr_d = (rr_q == RR_LAST) ? '0 : rr_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      data_q    <= '{default: '0};
      sel_err_q <= 1'b0;
      rr_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
      rr_q      <= rr_d;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_data[k*DATA_W +: DATA_W] = data_q[k];
  end

  assign out_valid = valid_q;
  assign sel_err   = sel_err_q;
  assign rr_ptr    = (ROUND_ROBIN != 0) ? rr_q : '0;

endmodule

// File: tb/tb_demux_stream_registered.sv
// tb/tb_demux_stream_registered.sv - scoreboard bench for demux_stream_registered
// Three instances: select mode x4, round-robin x3, select mode x3 (out-of-range select reachable).
module tb_demux_stream_registered;

  localparam int NO  [3] = '{4, 3, 3};
  localparam int RRM [3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv   [3];
  logic [1:0] sel  [3];
  logic [7:0] dat  [3];
  logic [3:0] ordy [3];
  logic       ir   [3];
  logic       se   [3];
  logic [1:0] rr   [3];
  logic [3:0] ov   [3];
  logic [31:0] od  [3];

  logic [3:0]  ov0;
  logic [2:0]  ov1, ov2;
  logic [31:0] od0;
  logic [23:0] od1, od2;

  assign ov[0] = ov0;
  assign ov[1] = {1'b0, ov1};
  assign ov[2] = {1'b0, ov2};
  assign od[0] = od0;
  assign od[1] = {8'h00, od1};
  assign od[2] = {8'h00, od2};

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q [12][$];
  int         rrm     [3] = '{0, 0, 0};
  logic       err_exp [3] = '{1'b0, 1'b0, 1'b0};
  int         acc     [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  demux_stream_registered #(.DATA_W(8), .NUM_OUT(4), .ROUND_ROBIN(0), .SEL_W(2)) u_sel4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(dat[0]),
    .in_sel(sel[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0),
    .sel_err(se[0]), .rr_ptr(rr[0]));

  demux_stream_registered #(.DATA_W(8), .NUM_OUT(3), .ROUND_ROBIN(1), .SEL_W(2)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(dat[1]),
    .in_sel(sel[1]), .out_valid(ov1), .out_ready(ordy[1][2:0]), .out_data(od1),
    .sel_err(se[1]), .rr_ptr(rr[1]));

  demux_stream_registered #(.DATA_W(8), .NUM_OUT(3), .ROUND_ROBIN(0), .SEL_W(2)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(dat[2]),
    .in_sel(sel[2]), .out_valid(ov2), .out_ready(ordy[2][2:0]), .out_data(od2),
    .sel_err(se[2]), .rr_ptr(rr[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: per-channel FIFO of accepted-but-undelivered beats.
  always @(negedge clk) begin
    int         dst;
    logic [3:0] exp_ov;
    logic       exp_ir;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        chk("rst_in_ready", 32'(ir[i]), 0);
        chk("rst_out_valid", 32'(ov[i]), 0);
        chk("rst_rr_ptr", 32'(rr[i]), 0);
        chk("rst_sel_err", 32'(se[i]), 0);
        for (int k = 0; k < 4; k++) q[i*4+k].delete();
        rrm[i]     = 0;
        err_exp[i] = 1'b0;
      end else begin
        exp_ov = '0;
        for (int k = 0; k < NO[i]; k++) exp_ov[k] = (q[i*4+k].size() != 0);
        chk("out_valid", 32'(ov[i]), 32'(exp_ov));
        chk("sel_err", 32'(se[i]), 32'(err_exp[i]));
        chk("rr_ptr", 32'(rr[i]), (RRM[i] != 0) ? rrm[i] : 0);
        dst    = (RRM[i] != 0) ? rrm[i] : int'(sel[i]);
        exp_ir = (dst >= NO[i]) || !exp_ov[dst] || ordy[i][dst];
        chk("in_ready", 32'(ir[i]), 32'(exp_ir));
        for (int k = 0; k < NO[i]; k++) begin
          if (ov[i][k] && ordy[i][k] && q[i*4+k].size() != 0) begin
            chk("out_data", 32'(od[i][k*8 +: 8]), 32'(q[i*4+k].pop_front()));
          end
        end
        err_exp[i] = 1'b0;
        if (iv[i] && ir[i]) begin
          acc[i]++;
          if (dst < NO[i]) q[i*4+dst].push_back(dat[i]);
          else err_exp[i] = 1'b1;
          if (RRM[i] != 0) rrm[i] = (rrm[i] + 1) % NO[i];
        end
      end
    end
  end

  task automatic send(input int i, input int s, input logic [7:0] d);
    int n = 0;
    iv[i] = 1'b1; sel[i] = 2'(s); dat[i] = d;
    do begin @(negedge clk); n++; end while (!ir[i] && n < 200);
    if (!ir[i]) begin
      n_checks++;
      $display("FAIL send_timeout: inst %0d never ready, required ready within 200 cycles", i);
    end
    @(posedge clk); #1;
    iv[i] = 1'b0;
  endtask

  task automatic soak(input int i, input int n);
    int cyc   = 0;
    int start = acc[i];
    while ((acc[i] - start) < n && cyc < 60000) begin
      @(posedge clk); #1;
      iv[i]   = ($urandom_range(0, 3) != 0);
      sel[i]  = 2'($urandom_range(0, 3));
      dat[i]  = 8'($urandom);
      ordy[i] = 4'($urandom) | 4'($urandom);
      cyc++;
    end
    if ((acc[i] - start) < n) begin
      n_checks++;
      $display("FAIL soak_timeout: inst %0d accepted %0d beats, required %0d", i, acc[i] - start, n);
    end
    iv[i] = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required finish before 900000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; sel[i] = '0; dat[i] = '0; ordy[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // select mode: latency and routing
    ordy[0] = 4'hF;
    send(0, 2, 8'hA1);
    chk("t2_valid_ch2", 32'(ov[0][2]), 1);
    chk("t2_data_ch2", 32'(od[0][23:16]), 32'hA1);
    send(0, 0, 8'hB2);
    chk("t2_data_ch0", 32'(od[0][7:0]), 32'hB2);
    repeat (2) @(posedge clk);

    // backpressure on ch1, then no-bubble refill
    #1 ordy[0] = 4'b1101;
    send(0, 1, 8'h11);
    iv[0] = 1'b1; sel[0] = 2'd1; dat[0] = 8'h22;
    repeat (3) begin @(negedge clk); chk("t3_stall_ready", 32'(ir[0]), 0); end
    @(posedge clk); #1 ordy[0] = 4'hF;
    send(0, 1, 8'h22);
    chk("t3_refill_valid", 32'(ov[0][1]), 1);
    chk("t3_refill_data", 32'(od[0][15:8]), 32'h22);
    repeat (2) @(posedge clk);

    // round robin over 3 channels
    #1 ordy[1] = 4'h7;
    for (int b = 0; b < 7; b++) send(1, 0, 8'(b));
    chk("t4_rr_end", 32'(rr[1]), 1);
    repeat (2) @(posedge clk);

    // out-of-range select drops the beat
    #1 ordy[2] = 4'h0;
    send(2, 1, 8'h55);
    send(2, 3, 8'hEE);
    chk("t5_sel_err", 32'(se[2]), 1);
    chk("t5_valid_kept", 32'(ov[2]), 32'b010);
    @(posedge clk); #1;
    chk("t5_sel_err_clear", 32'(se[2]), 0);
    ordy[2] = 4'h7;
    repeat (2) @(posedge clk);

    // asynchronous reset with held beats
    #1 ordy[0] = 4'h0;
    send(0, 0, 8'h10);
    send(0, 1, 8'h20);
    send(0, 3, 8'h30);
    chk("t1_pre_valid", 32'(ov[0]), 32'b1011);
    rst_n = 1'b0;
    #1;
    chk("t1_valid_cleared", 32'(ov[0]), 0);
    chk("t1_ready_low", 32'(ir[0]), 0);
    chk("t1_rr_cleared", 32'(rr[1]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ordy[1] = 4'h0;
    send(1, 2, 8'h77);
    chk("t1_rr_first_ch0", 32'(ov[1]), 32'b0001);
    chk("t1_rr_first_data", 32'(od[1][7:0]), 32'h77);
    ordy[1] = 4'h7;
    repeat (2) @(posedge clk);

    // random soak on all three instances
    fork
      soak(0, 10000);
      soak(1, 3000);
      soak(2, 3000);
    join
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 4'hF; end
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < NO[i]; k++)
        chk("leftover_beats", 32'(q[i*4+k].size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
